mac_acc_pipe: RTL and testbench

//  Parametrised pipelined multiply-accumulate engine; successor to the single-product MAC stage.

---
 rtl/mac_pkg.sv | 39 +++
 rtl/mac_mul_pipe.sv | 51 +++++
 rtl/mac_acc_pipe.sv | 141 ++++++++++++++
 tb/tb_mac_acc_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants, sideband type and helpers for the pipelined MAC engine.
package mac_pkg;

  localparam int unsigned DefInputWidth = 16;
  localparam int unsigned DefAccWidth   = 40;
  localparam int unsigned DefMulStages  = 2;

  localparam int unsigned MaxProdWidth = 64;
  localparam int unsigned MaxAccWidth  = 128;

  // Input register plus accumulator register around the multiplier stages.
  localparam int unsigned LatencyOverhead = 2;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } mac_side_t;

  function automatic int unsigned mac_latency(input int unsigned mul_stages);
    return mul_stages + LatencyOverhead;
  endfunction

  // prod must arrive zero-extended above prod_w; bits from prod_w upward get the extension bit.
  function automatic logic [MaxAccWidth-1:0] sext_prod(input logic [MaxProdWidth-1:0] prod,
                                                       input int unsigned prod_w,
                                                       input bit is_signed);
    logic [5:0]             msb_idx;
    logic                   ext;
    logic [MaxAccWidth-1:0] low_mask;
    logic [MaxAccWidth-1:0] zext;
    msb_idx  = 6'(prod_w - 1);
    ext      = is_signed & prod[msb_idx];
    low_mask = (MaxAccWidth'(1) << prod_w) - MaxAccWidth'(1);
    zext     = MaxAccWidth'(prod);
    return ext ? (zext | ~low_mask) : zext;
  endfunction

endpackage

// File: rtl/mac_mul_pipe.sv
// Registered multiplier with MUL_STAGES output registers and a matching valid/first/last
// sideband shift register.
module mac_mul_pipe
  import mac_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DefInputWidth,
  parameter int unsigned MUL_STAGES  = DefMulStages,
  parameter bit          SIGNED      = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [INPUT_WIDTH-1:0]   i_a,
  input  logic [INPUT_WIDTH-1:0]   i_b,
  input  mac_side_t                i_side,
  output logic [2*INPUT_WIDTH-1:0] o_prod,
  output mac_side_t                o_side
);

  localparam int unsigned ProdWidth = 2 * INPUT_WIDTH;

  logic [ProdWidth-1:0] a_ext, b_ext, prod_d;
  logic [ProdWidth-1:0] prod_q [MUL_STAGES];
  mac_side_t            side_q [MUL_STAGES];

  // Extending both operands to the product width keeps the low bits exact in either mode.
  always_comb begin
    a_ext  = {{INPUT_WIDTH{SIGNED & i_a[INPUT_WIDTH-1]}}, i_a};
    b_ext  = {{INPUT_WIDTH{SIGNED & i_b[INPUT_WIDTH-1]}}, i_b};
    prod_d = a_ext * b_ext;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
        side_q[i] <= '0;
      end
    end else begin
      prod_q[0] <= prod_d;
      side_q[0] <= i_side;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
        side_q[i] <= side_q[i-1];
      end
    end
  end

  assign o_prod = prod_q[MUL_STAGES-1];
  assign o_side = side_q[MUL_STAGES-1];

endmodule

// File: rtl/mac_acc_pipe.sv
// Pipelined per-frame multiply-accumulate engine. Define MAC_SAT_EN for saturating
// accumulation with a sticky per-frame overflow flag; otherwise the accumulator wraps.
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DefInputWidth,
  parameter int unsigned ACC_WIDTH   = DefAccWidth,
  parameter int unsigned MUL_STAGES  = DefMulStages,
  parameter bit          SIGNED      = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INPUT_WIDTH-1:0] i_a,
  input  logic [INPUT_WIDTH-1:0] i_b,
  input  logic                   i_valid,
  input  logic                   i_first,
  input  logic                   i_last,
  output logic [ACC_WIDTH-1:0]   o_val,
  output logic                   o_valid,
  output logic                   o_last,
  output logic                   o_ovf
);

  localparam int unsigned ProdWidth = 2 * INPUT_WIDTH;

  logic [INPUT_WIDTH-1:0] a_q, b_q;
  mac_side_t              side_in_q, side_mul;
  logic [ProdWidth-1:0]   prod;
  logic [MaxAccWidth-1:0] prod_wide;
  logic [ACC_WIDTH-1:0]   prod_ext, sum;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   valid_q, valid_d, last_q, last_d;
  logic                   unused_prod_hi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q       <= '0;
      b_q       <= '0;
      side_in_q <= '0;
    end else begin
      a_q       <= i_a;
      b_q       <= i_b;
      side_in_q <= '{valid: i_valid, first: i_valid & i_first, last: i_valid & i_last};
    end
  end

  mac_mul_pipe #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .MUL_STAGES (MUL_STAGES),
    .SIGNED     (SIGNED)
  ) u_mul (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_a   (a_q),
    .i_b   (b_q),
    .i_side(side_in_q),
    .o_prod(prod),
    .o_side(side_mul)
  );

  assign prod_wide      = sext_prod(MaxProdWidth'(prod), ProdWidth, SIGNED);
  assign prod_ext       = prod_wide[ACC_WIDTH-1:0];
  assign unused_prod_hi = ^prod_wide;

`ifdef MAC_SAT_EN
  logic                 carry, ovf_add, ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] sat_val;

  assign {carry, sum} = {1'b0, acc_q} + {1'b0, prod_ext};
  assign ovf_add = SIGNED ? ((acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                             (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                          : carry;
  // Signed overflow only happens with equal operand signs, so the product sign picks the rail.
  assign sat_val = !SIGNED ? '1 :
                   prod_ext[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
  assign sum = acc_q + prod_ext;
`endif

  always_comb begin
    acc_d   = acc_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
`ifdef MAC_SAT_EN
    ovf_d   = ovf_q;
`endif
    if (side_mul.valid) begin
      valid_d = 1'b1;
      last_d  = side_mul.last;
      if (side_mul.first) begin
        acc_d = prod_ext;
`ifdef MAC_SAT_EN
        ovf_d = 1'b0;
`endif
      end else begin
`ifdef MAC_SAT_EN
        if (ovf_add) begin
          acc_d = sat_val;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum;
        end
`else
        acc_d = sum;
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

`ifdef MAC_SAT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_ovf = ovf_q;
`else
  assign o_ovf = 1'b0;
`endif

  assign o_val   = acc_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed bench for mac_acc_pipe: default (signed, 40-bit), 32-bit signed and unsigned
// instances share one stimulus stream.
module tb_mac_acc_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        valid = 1'b0, first = 1'b0, last = 1'b0;

  logic [39:0] val;
  logic        ovalid, olast, ovf;
  logic [31:0] val32;
  logic        ovalid32, olast32, ovf32;
  logic [39:0] valu;
  logic        ovalidu, olastu, ovfu;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_acc_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_valid(valid), .i_first(first),
    .i_last(last), .o_val(val), .o_valid(ovalid), .o_last(olast), .o_ovf(ovf)
  );

  mac_acc_pipe #(.ACC_WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_valid(valid), .i_first(first),
    .i_last(last), .o_val(val32), .o_valid(ovalid32), .o_last(olast32), .o_ovf(ovf32)
  );

  mac_acc_pipe #(.SIGNED(1'b0)) dutu (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_valid(valid), .i_first(first),
    .i_last(last), .o_val(valu), .o_valid(ovalidu), .o_last(olastu), .o_ovf(ovfu)
  );

  // Present one input cycle, then sample just after the capturing edge.
  task automatic drive(input logic [15:0] a_v, input logic [15:0] b_v,
                       input logic v, input logic f, input logic l);
    a = a_v; b = b_v; valid = v; first = f; last = l;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (val !== 40'd0) begin errors++; $display("FAIL reset_val got %0h want 0", val); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ovalid); end
    checks++; if (olast !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", olast); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (val32 !== 32'd0) begin errors++; $display("FAIL reset_val32 got %0h want 0", val32); end
    checks++; if (valu !== 40'd0) begin errors++; $display("FAIL reset_valu got %0h want 0", valu); end
  endtask

  task automatic test_frame();
    drive(16'd3, 16'd4, 1'b1, 1'b1, 1'b0);
    drive(16'd5, 16'd6, 1'b1, 1'b0, 1'b0);
    drive(16'hFFFE, 16'd7, 1'b1, 1'b0, 1'b1);
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL frame_early_valid got %b want 0", ovalid); end
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovalid !== 1'b1 || val !== 40'd12 || olast !== 1'b0) begin
      errors++; $display("FAIL frame_s0 got v=%b val=%0d l=%b want v=1 val=12 l=0", ovalid, val, olast);
    end
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovalid !== 1'b1 || val !== 40'd42 || olast !== 1'b0) begin
      errors++; $display("FAIL frame_s1 got v=%b val=%0d l=%b want v=1 val=42 l=0", ovalid, val, olast);
    end
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovalid !== 1'b1 || val !== 40'd28 || olast !== 1'b1) begin
      errors++; $display("FAIL frame_s2 got v=%b val=%0d l=%b want v=1 val=28 l=1", ovalid, val, olast);
    end
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovalid !== 1'b0 || olast !== 1'b0 || val !== 40'd28) begin
      errors++; $display("FAIL frame_hold got v=%b l=%b val=%0d want v=0 l=0 val=28", ovalid, olast, val);
    end
  endtask

  task automatic test_single();
    drive(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovalid !== 1'b1 || val !== 40'h0040000000 || olast !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL single got v=%b val=%0h l=%b ovf=%b want v=1 val=40000000 l=1 ovf=0",
               ovalid, val, olast, ovf);
    end
  endtask

  task automatic test_gapped();
    int   sa [10] = '{2, 0, 0, 3, 0, 0, 0, 0, 0, 0};
    logic sv [10] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic sf [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic sl [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic ev [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    int   eval [10] = '{0, 0, 0, 4, 4, 4, 13, 13, 13, 13};
    int   pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive(16'(sa[i]), 16'(sa[i]), sv[i], sf[i], sl[i]);
      if (ovalid === 1'b1) pulses++;
      checks++; if (ovalid !== ev[i]) begin
        errors++; $display("FAIL gap_valid[%0d] got %b want %b", i, ovalid, ev[i]);
      end
      if (i >= 3) begin
        checks++; if (val !== 40'(eval[i])) begin
          errors++; $display("FAIL gap_val[%0d] got %0d want %0d", i, val, eval[i]);
        end
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL gap_pulses got %0d want 2", pulses); end
  endtask

  task automatic test_wrap_sat();
    logic [31:0] exp_v;
    logic        exp_o;
`ifdef MAC_SAT_EN
    exp_v = 32'h7FFFFFFF; exp_o = 1'b1;
`else
    exp_v = 32'hBFFD0003; exp_o = 1'b0;
`endif
    drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (val32 !== 32'h3FFF0001) begin errors++; $display("FAIL wrap_s0 got %0h want 3fff0001", val32); end
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (val32 !== 32'h7FFE0002 || ovf32 !== 1'b0) begin
      errors++; $display("FAIL wrap_s1 got %0h ovf=%b want 7ffe0002 ovf=0", val32, ovf32);
    end
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (val32 !== exp_v || ovf32 !== exp_o || olast32 !== 1'b1) begin
      errors++; $display("FAIL wrap_s2 got %0h ovf=%b l=%b want %0h ovf=%b l=1", val32, ovf32, olast32, exp_v, exp_o);
    end
    checks++; if (val !== 40'h00BFFD0003 || ovf !== 1'b0) begin
      errors++; $display("FAIL wide_no_ovf got %0h ovf=%b want bffd0003 ovf=0", val, ovf);
    end
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (val32 !== exp_v || ovf32 !== exp_o) begin
      errors++; $display("FAIL wrap_hold got %0h ovf=%b want %0h ovf=%b", val32, ovf32, exp_v, exp_o);
    end
    drive(16'd1, 16'd1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (val32 !== 32'd1 || ovf32 !== 1'b0 || ovalid32 !== 1'b1) begin
      errors++; $display("FAIL wrap_clear got %0h ovf=%b v=%b want 1 ovf=0 v=1", val32, ovf32, ovalid32);
    end
  endtask

  task automatic test_reset_inflight();
    drive(16'd9, 16'd9, 1'b1, 1'b1, 1'b0);
    drive(16'd8, 16'd8, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (ovalid !== 1'b0 || val !== 40'd0) begin
        errors++; $display("FAIL rst_drop[%0d] got v=%b val=%0d want v=0 val=0", i, ovalid, val);
      end
    end
    drive(16'd1, 16'd1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovalid !== 1'b1 || val !== 40'd1 || olast !== 1'b1) begin
      errors++; $display("FAIL rst_after got v=%b val=%0d l=%b want v=1 val=1 l=1", ovalid, val, olast);
    end
  endtask

  task automatic test_unsigned();
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    drive(16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovalidu !== 1'b1 || valu !== 40'hFFFE0001 || olastu !== 1'b0) begin
      errors++; $display("FAIL uns_s0 got v=%b val=%0h l=%b want v=1 val=fffe0001 l=0", ovalidu, valu, olastu);
    end
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovalidu !== 1'b1 || valu !== 40'hFFFE0002 || olastu !== 1'b1) begin
      errors++; $display("FAIL uns_s1 got v=%b val=%0h l=%b want v=1 val=fffe0002 l=1", ovalidu, valu, olastu);
    end
    checks++; if (val !== 40'd2) begin errors++; $display("FAIL signed_neg1 got %0d want 2", val); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_single();
    test_gapped();
    test_wrap_sat();
    test_reset_inflight();
    test_unsigned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
